// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: state encoding, width defaults
// and the bit-index width helper.
package ccff_loader_pkg;

    localparam int unsigned WORD_W_DEFAULT = 32;
    localparam int unsigned CNT_W_DEFAULT  = 20;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StFetch = 2'd1;
    localparam state_t StShift = 2'd2;

    // Bit-index width for a word, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned BIT_IDX_W_DEFAULT = idx_w(WORD_W_DEFAULT);

endpackage

// File: rtl/ccff_loader_shreg.sv
// Parallel-load serialiser: holds one bitstream word and presents the bit selected by a
// running index, bit 0 first.
module ccff_loader_shreg
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEFAULT,
    parameter int unsigned IDX_W  = idx_w(WORD_W)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              advance_i,
    output logic              bit_o,
    output logic              last_o
);

    logic [WORD_W-1:0] shreg_q;
    logic [IDX_W-1:0]  idx_q;

    // A load wins over advance so a streamed word starts at bit 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
            idx_q   <= '0;
        end else if (advance_i) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    assign bit_o  = shreg_q[idx_q];
    assign last_o = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: fetches bitstream words and shifts them serially into the
// fabric chain, with zero-bubble streaming, underrun stalls, abort and status flags.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              cfg_done,
    output logic              err,
    output logic              tail_last
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              done_q, done_d;
    logic              cfg_done_q, cfg_done_d;
    logic              err_q, err_d;
    logic              tail_last_q, tail_last_d;

    logic              load;
    logic              advance;
    logic              shreg_bit;
    logic              word_last;
    logic              in_shift;
    logic              last_bit;
    logic              accept;

    ccff_loader_shreg #(
        .WORD_W (WORD_W)
    ) u_shreg (
        .clk_i     (prog_clk),
        .rst_ni    (pReset),
        .load_i    (load),
        .data_i    (s_data),
        .advance_i (advance),
        .bit_o     (shreg_bit),
        .last_o    (word_last)
    );

    assign in_shift = (state_q == StShift);
    assign last_bit = (remaining_q == CNT_W'(1));
    assign s_ready  = (state_q == StFetch) || (in_shift && word_last && !last_bit);
    assign accept   = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        cfg_done_d  = cfg_done_q;
        err_d       = err_q;
        tail_last_d = tail_last_q;
        load        = 1'b0;
        advance     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (chain_len != '0) begin
                        state_d     = StFetch;
                        remaining_d = chain_len;
                        cfg_done_d  = 1'b0;
                        err_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                if (abort) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (accept) begin
                    load    = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    remaining_d = remaining_q - CNT_W'(1);
                    advance     = 1'b1;
                    if (last_bit) begin
                        tail_last_d = ccff_tail;
                        done_d      = 1'b1;
                        cfg_done_d  = 1'b1;
                        state_d     = StIdle;
                    end else if (word_last) begin
                        // Stream the next word without a bubble, or stall in fetch.
                        if (accept) begin
                            load = 1'b1;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            done_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            err_q       <= 1'b0;
            tail_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            cfg_done_q  <= cfg_done_d;
            err_q       <= err_d;
            tail_last_q <= tail_last_d;
        end
    end

    assign ccff_head     = in_shift & shreg_bit;
    assign ccff_shift_en = in_shift;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign cfg_done      = cfg_done_q;
    assign err           = err_q;
    assign tail_last     = tail_last_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Randomized bench for ccff_loader against a bit-queue reference model of the chain load.
module tb_ccff_loader;

    localparam int W  = 32;
    localparam int CW = 20;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start;
    logic          abort;
    logic [CW-1:0] chain_len;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          cfg_done;
    logic          err;
    logic          tail_last;

    ccff_loader #(
        .WORD_W (W),
        .CNT_W  (CW)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .abort         (abort),
        .chain_len     (chain_len),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .cfg_done      (cfg_done),
        .err           (err),
        .tail_last     (tail_last)
    );

    always #5 prog_clk = ~prog_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a load is a stream of chain_len bits drawn from accepted words.
    bit           m_active = 0;
    bit           m_cfg_done = 0;
    bit           m_err = 0;
    bit           m_tail = 0;
    bit           m_done = 0;
    int           m_len = 0;
    int           m_shifted = 0;
    int           m_acc_words = 0;
    bit           m_bits[$];
    logic [W-1:0] offer_q[$];
    int           n_shift, n_done, n_gap;

    function automatic bit m_sh();
        return m_active && (m_bits.size() > 0);
    endfunction

    function automatic bit m_ready();
        int sh;
        sh = m_sh() ? 1 : 0;
        return m_active && ((m_bits.size() - sh) == 0) && ((m_len - m_shifted - sh) > 0);
    endfunction

    // Called at a falling edge: check this cycle's outputs, drive inputs, advance the model.
    task automatic cycle(input bit st, input logic [CW-1:0] len, input bit ab, input bit vld);
        bit sh, rdy, acc;
        sh  = m_sh();
        rdy = m_ready();
        check("busy", busy, m_active);
        check("shift_en", ccff_shift_en, sh);
        check("head", ccff_head, sh ? m_bits[0] : 1'b0);
        check("s_ready", s_ready, rdy);
        check("done", done, m_done);
        check("cfg_done", cfg_done, m_cfg_done);
        check("err", err, m_err);
        check("tail_last", tail_last, m_tail);
        if (ccff_shift_en) n_shift++;
        if (done) n_done++;
        if (busy && !ccff_shift_en && n_shift > 0) n_gap++;

        start     = st;
        chain_len = len;
        abort     = ab;
        s_valid   = vld;
        s_data    = (offer_q.size() > 0) ? offer_q[0] : W'($urandom);
        ccff_tail = 1'($urandom);

        acc    = vld && rdy && !ab;
        m_done = 0;
        if (m_active) begin
            if (sh) begin
                void'(m_bits.pop_front());
                m_shifted++;
            end
            if (ab) begin
                m_active = 0;
                m_err    = 1;
                m_bits.delete();
            end else begin
                if (acc) begin
                    for (int i = 0; i < W; i++) m_bits.push_back(s_data[i]);
                    if (offer_q.size() > 0) void'(offer_q.pop_front());
                    m_acc_words++;
                end
                if (sh && m_shifted == m_len) begin
                    m_active   = 0;
                    m_done     = 1;
                    m_cfg_done = 1;
                    m_tail     = ccff_tail;
                    m_bits.delete();
                end
            end
        end else if (st) begin
            if (len != '0) begin
                m_active   = 1;
                m_len      = int'(len);
                m_shifted  = 0;
                m_cfg_done = 0;
                m_err      = 0;
            end else begin
                m_err = 1;
            end
        end
        @(negedge prog_clk);
    endtask

    task automatic run_load(input int len, input int vpct, input int abort_at, input int gap,
                            input bit stray);
        int gap_cnt = 0;
        int cyc = 0;
        bit aborted = 0;
        bit ab, vld, st;
        n_shift = 0;
        n_done = 0;
        n_gap = 0;
        m_acc_words = 0;
        while (offer_q.size() < 8) offer_q.push_back(W'($urandom));
        cycle(1'b1, CW'(len), 1'b0, 1'b0);
        while (m_active && cyc < 4 * len + 100) begin
            ab = (abort_at >= 0) && !aborted && m_sh() && (m_shifted == abort_at);
            if (ab) aborted = 1;
            if (gap > 0 && m_acc_words == 1 && gap_cnt < gap) begin
                vld = 1'b0;
                if (m_ready()) gap_cnt++;
            end else begin
                vld = ($urandom_range(99) < vpct);
            end
            st = stray && ($urandom_range(15) == 0);
            cycle(st, CW'($urandom_range(50, 1)), ab, vld);
            cyc++;
        end
        check("load_timeout", m_active, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        offer_q.delete();
    endtask

    initial begin
        pReset    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        chain_len = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        ccff_tail = 1'b0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_ready", s_ready, 1'b0);
        check("rst_shift_en", ccff_shift_en, 1'b0);
        check("rst_cfg_done", cfg_done, 1'b0);
        @(negedge prog_clk);
        pReset = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Single word 0xA5, eight bits.
        offer_q.push_back(W'(32'h0000_00A5));
        run_load(8, 100, -1, 0, 1'b0);
        check("a5_shifts", n_shift, 8);
        check("a5_done_cnt", n_done, 1);
        check("a5_cfg_done", cfg_done, 1'b1);

        // Three streamed words, partial final word.
        run_load(70, 100, -1, 0, 1'b0);
        check("w70_shifts", n_shift, 70);
        check("w70_bubbles", n_gap, 0);
        check("w70_done_cnt", n_done, 1);

        // Underrun stall of five cycles after word 1.
        run_load(64, 100, -1, 5, 1'b0);
        check("w64_shifts", n_shift, 64);
        check("w64_stall", n_gap, 5);

        // Zero-length start.
        n_done = 0;
        cycle(1'b1, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("zero_err", err, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_done_cnt", n_done, 0);

        // Abort while shifting bit 10.
        run_load(40, 100, 10, 0, 1'b0);
        check("abort_shifts", n_shift, 11);
        check("abort_done_cnt", n_done, 0);
        check("abort_err", err, 1'b1);
        run_load(16, 100, -1, 0, 1'b0);
        check("restart_err", err, 1'b0);
        check("restart_done_cnt", n_done, 1);

        // Randomized loads with irregular valid, stray starts and occasional aborts.
        for (int k = 0; k < 10; k++) begin
            int len, ab_at;
            len   = $urandom_range(150, 1);
            ab_at = ($urandom_range(9) < 3) ? $urandom_range(len - 1) : -1;
            run_load(len, $urandom_range(100, 30), ab_at, 0, 1'b1);
            check("rnd_shifts", n_shift, (ab_at >= 0) ? ab_at + 1 : len);
            check("rnd_done_cnt", n_done, (ab_at >= 0) ? 0 : 1);
        end

        // Asynchronous reset in the middle of a load.
        while (offer_q.size() < 8) offer_q.push_back(W'($urandom));
        cycle(1'b1, CW'(100), 1'b0, 1'b0);
        for (int c = 0; c < 500 && m_shifted < 20; c++) cycle(1'b0, '0, 1'b0, 1'b1);
        #2;
        pReset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_shift_en", ccff_shift_en, 1'b0);
        check("arst_head", ccff_head, 1'b0);
        check("arst_ready", s_ready, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_cfg_done", cfg_done, 1'b0);
        check("arst_err", err, 1'b0);
        check("arst_tail_last", tail_last, 1'b0);
        m_active   = 0;
        m_cfg_done = 0;
        m_err      = 0;
        m_tail     = 0;
        m_done     = 0;
        m_bits.delete();
        offer_q.delete();
        s_valid = 1'b0;
        @(negedge prog_clk);
        pReset = 1'b1;
        n_done = 0;
        for (int c = 0; c < 4; c++) cycle(1'b0, '0, 1'b0, 1'b0);
        check("arst_no_done", n_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
